// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, latch control bundle, load-use test.
// Pure declarations; no timing or backpressure of its own.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic pc_wen;
        logic ifid_wen;
        logic ifid_flush;
        logic idex_wen;
        logic idex_flushed;
        logic exmem_wen;
        logic exmem_flush;
        logic memwb_wen;
        logic memwb_flush;
    } latch_ctl_t;

    // r0 is hardwired, so a load targeting it never creates a dependency.
    function automatic logic load_use_hit(
        input logic             memread,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt
    );
        return memread && (rd != '0) && ((rd == rs) || (rd == rt));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs and per-latch control outputs between the pipeline datapath and the hazard controller.
// Combinational bundle; the controller side is the slave modport.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic             ihit;
    logic             dhit;
    logic             mem_req_mem;
    logic             halt_mem;
    logic             memread_ex;
    logic [REG_W-1:0] rd_ex;
    logic [REG_W-1:0] rs_id;
    logic [REG_W-1:0] rt_id;
    logic             redirect_ex;
    logic             jump_id;

    logic             pc_wen;
    logic             ifid_wen;
    logic             ifid_flush;
    logic             idex_wen;
    logic             idex_flushed;
    logic             exmem_wen;
    logic             exmem_flush;
    logic             memwb_wen;
    logic             memwb_flush;

    modport master (
        output ihit, dhit, mem_req_mem, halt_mem, memread_ex, rd_ex, rs_id, rt_id,
               redirect_ex, jump_id,
        input  pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flushed,
               exmem_wen, exmem_flush, memwb_wen, memwb_flush
    );

    modport slave (
        input  ihit, dhit, mem_req_mem, halt_mem, memread_ex, rd_ex, rs_id, rt_id,
               redirect_ex, jump_id,
        output pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flushed,
               exmem_wen, exmem_flush, memwb_wen, memwb_flush
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: fixed-priority latch wen/flush generation, RUN/DWAIT/HALTED FSM, saturating counters.
// Controls are combinational (same-cycle latch edge); state/halt/counters update on posedge clk; a data miss freezes every latch.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              nRst,
    pipe_hazard_ctrl_if.slave hz,
    output logic              halt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hazard_state_t    state_q, state_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    latch_ctl_t ctl;
    logic       mem_freeze;
    logic       load_use;

    assign mem_freeze = hz.mem_req_mem && !hz.dhit;
    assign load_use   = load_use_hit(hz.memread_ex, hz.rd_ex, hz.rs_id, hz.rt_id);

    always_comb begin
        ctl = '0;
        if (!nRst) begin
            if (state_q == HALTED || mem_freeze) begin
                ctl = '0;
            end else if (hz.redirect_ex) begin
                // Redirect outranks load-use: the dependent instruction in ID is squashed.
                ctl.pc_wen       = 1'b1;
                ctl.ifid_wen     = 1'b1;
                ctl.ifid_flush   = 1'b1;
                ctl.idex_wen     = 1'b1;
                ctl.idex_flushed = 1'b1;
                ctl.exmem_wen    = 1'b1;
                ctl.memwb_wen    = 1'b1;
            end else if (load_use) begin
                ctl.idex_wen     = 1'b1;
                ctl.idex_flushed = 1'b1;
                ctl.exmem_wen    = 1'b1;
                ctl.memwb_wen    = 1'b1;
            end else if (hz.jump_id && hz.ihit) begin
                ctl.pc_wen       = 1'b1;
                ctl.ifid_wen     = 1'b1;
                ctl.ifid_flush   = 1'b1;
                ctl.idex_wen     = 1'b1;
                ctl.exmem_wen    = 1'b1;
                ctl.memwb_wen    = 1'b1;
            end else if (!hz.ihit) begin
                ctl.ifid_wen     = 1'b1;
                ctl.ifid_flush   = 1'b1;
                ctl.idex_wen     = 1'b1;
                ctl.exmem_wen    = 1'b1;
                ctl.memwb_wen    = 1'b1;
            end else begin
                ctl.pc_wen       = 1'b1;
                ctl.ifid_wen     = 1'b1;
                ctl.idex_wen     = 1'b1;
                ctl.exmem_wen    = 1'b1;
                ctl.memwb_wen    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        halt_d      = halt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (state_q != HALTED) begin
            // A halt is only taken on a cycle where the pipeline actually advances.
            if (hz.halt_mem && !mem_freeze) begin
                state_d = HALTED;
                halt_d  = 1'b1;
            end else if (state_q == RUN && mem_freeze) begin
                state_d = DWAIT;
            end else if (state_q == DWAIT && hz.dhit) begin
                state_d = RUN;
            end

            if (!ctl.pc_wen && stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            if (ctl.ifid_flush && flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge nRst) begin
        if (nRst) begin
            state_q     <= RUN;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.pc_wen       = ctl.pc_wen;
    assign hz.ifid_wen     = ctl.ifid_wen;
    assign hz.ifid_flush   = ctl.ifid_flush;
    assign hz.idex_wen     = ctl.idex_wen;
    assign hz.idex_flushed = ctl.idex_flushed;
    assign hz.exmem_wen    = ctl.exmem_wen;
    assign hz.exmem_flush  = ctl.exmem_flush;
    assign hz.memwb_wen    = ctl.memwb_wen;
    assign hz.memwb_flush  = ctl.memwb_flush;

    assign halt      = halt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expectations, a negedge monitor pops and compares.
// Narrow counters so saturation is reachable in a short run.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int CNT_W = 4;

    // {pc, ifid_wen, ifid_flush, idex_wen, idex_flushed, exmem_wen, exmem_flush, memwb_wen, memwb_flush}
    localparam logic [8:0] C_ZERO = 9'b0_00_00_00_00;
    localparam logic [8:0] C_NORM = 9'b1_10_10_10_10;
    localparam logic [8:0] C_LU   = 9'b0_00_11_10_10;
    localparam logic [8:0] C_RED  = 9'b1_11_11_10_10;
    localparam logic [8:0] C_JMP  = 9'b1_11_10_10_10;
    localparam logic [8:0] C_MISS = 9'b0_11_10_10_10;

    typedef struct packed {
        logic       rst;
        logic       ihit;
        logic       dhit;
        logic       mem_req;
        logic       halt_mem;
        logic       memread;
        logic       redirect;
        logic       jump;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
    } in_t;

    typedef struct {
        logic [8:0] ctl;
        logic       halt;
        int         stall;
        int         flush;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    exp_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    bit   done   = 1'b0;

    pipe_hazard_ctrl_if hz_if ();

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .nRst      (rst),
        .hz        (hz_if.slave),
        .halt      (halt),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic in_t nrm();
        in_t n;
        n      = '0;
        n.ihit = 1'b1;
        n.rd   = 5'd1;
        n.rs   = 5'd2;
        n.rt   = 5'd3;
        return n;
    endfunction

    task automatic apply(input in_t v);
        rst               = v.rst;
        hz_if.ihit        = v.ihit;
        hz_if.dhit        = v.dhit;
        hz_if.mem_req_mem = v.mem_req;
        hz_if.halt_mem    = v.halt_mem;
        hz_if.memread_ex  = v.memread;
        hz_if.redirect_ex = v.redirect;
        hz_if.jump_id     = v.jump;
        hz_if.rd_ex       = v.rd;
        hz_if.rs_id       = v.rs;
        hz_if.rt_id       = v.rt;
    endtask

    task automatic step(input in_t v, input logic [8:0] ctl, input logic h,
                        input int s, input int f, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        apply(v);
        e.ctl   = ctl;
        e.halt  = h;
        e.stall = s;
        e.flush = f;
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: the controls are combinational, so the DUT presents a response every cycle.
    initial begin
        exp_t       e;
        logic [8:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {hz_if.pc_wen, hz_if.ifid_wen, hz_if.ifid_flush, hz_if.idex_wen,
                       hz_if.idex_flushed, hz_if.exmem_wen, hz_if.exmem_flush,
                       hz_if.memwb_wen, hz_if.memwb_flush};
                tests++;
                if (got !== e.ctl) begin
                    fails++;
                    $display("FAIL %s ctl: got %b want %b", e.name, got, e.ctl);
                end
                tests++;
                if (halt !== e.halt) begin
                    fails++;
                    $display("FAIL %s halt: got %b want %b", e.name, halt, e.halt);
                end
                tests++;
                if (int'(stall_cnt) != e.stall || $isunknown(stall_cnt)) begin
                    fails++;
                    $display("FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt, e.stall);
                end
                tests++;
                if (int'(flush_cnt) != e.flush || $isunknown(flush_cnt)) begin
                    fails++;
                    $display("FAIL %s flush_cnt: got %0d want %0d", e.name, flush_cnt, e.flush);
                end
            end
        end
    end

    initial begin
        in_t v;
        apply(nrm());
        rst = 1'b1;

        v = nrm(); v.rst = 1'b1;
        step(v, C_ZERO, 1'b0, 0, 0, "reset");
        step(nrm(), C_NORM, 1'b0, 0, 0, "first_after_reset");

        v = nrm(); v.memread = 1'b1; v.rd = 5'd5; v.rs = 5'd5;
        step(v, C_LU, 1'b0, 0, 0, "load_use_rs");
        step(nrm(), C_NORM, 1'b0, 1, 0, "load_use_recover");
        v = nrm(); v.memread = 1'b1; v.rd = 5'd7; v.rt = 5'd7;
        step(v, C_LU, 1'b0, 1, 0, "load_use_rt");
        v = nrm(); v.memread = 1'b1; v.rd = 5'd0; v.rs = 5'd0;
        step(v, C_NORM, 1'b0, 2, 0, "load_r0_no_hazard");

        v = nrm(); v.memread = 1'b1; v.rd = 5'd5; v.rs = 5'd5; v.redirect = 1'b1;
        step(v, C_RED, 1'b0, 2, 0, "redirect_over_lu");
        v = nrm(); v.jump = 1'b1;
        step(v, C_JMP, 1'b0, 2, 1, "jump_id");
        v = nrm(); v.ihit = 1'b0;
        step(v, C_MISS, 1'b0, 2, 2, "fetch_miss");
        v = nrm(); v.ihit = 1'b0; v.jump = 1'b1;
        step(v, C_MISS, 1'b0, 3, 3, "jump_no_ihit");
        step(nrm(), C_NORM, 1'b0, 4, 4, "normal");

        v = nrm(); v.mem_req = 1'b1;
        step(v, C_ZERO, 1'b0, 4, 4, "dwait_1");
        step(v, C_ZERO, 1'b0, 5, 4, "dwait_2");
        step(v, C_ZERO, 1'b0, 6, 4, "dwait_3");
        v.dhit = 1'b1;
        step(v, C_NORM, 1'b0, 7, 4, "dwait_done");

        v = nrm(); v.mem_req = 1'b1; v.halt_mem = 1'b1;
        step(v, C_ZERO, 1'b0, 7, 4, "halt_frozen_1");
        step(v, C_ZERO, 1'b0, 8, 4, "halt_frozen_2");
        v.dhit = 1'b1;
        step(v, C_NORM, 1'b0, 9, 4, "halt_taken");
        step(nrm(), C_ZERO, 1'b1, 9, 4, "halted_1");
        v = nrm(); v.ihit = 1'b0;
        step(v, C_ZERO, 1'b1, 9, 4, "halted_no_count");

        v = nrm(); v.rst = 1'b1;
        step(v, C_ZERO, 1'b0, 0, 0, "reset_from_halt");
        step(nrm(), C_NORM, 1'b0, 0, 0, "run_again");
        v = nrm(); v.mem_req = 1'b1;
        for (int k = 0; k < 8; k++) step(v, C_ZERO, 1'b0, k, 0, "dwait_fill");
        v = nrm(); v.rst = 1'b1; v.mem_req = 1'b1;
        step(v, C_ZERO, 1'b0, 0, 0, "reset_mid_dwait");
        step(nrm(), C_NORM, 1'b0, 0, 0, "run_after_reset");

        v = nrm(); v.ihit = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(v, C_MISS, 1'b0, (k > 15) ? 15 : k, (k > 15) ? 15 : k, "saturate");
        end
        v = nrm(); v.halt_mem = 1'b1;
        step(v, C_NORM, 1'b0, 15, 15, "halt_no_freeze");
        step(nrm(), C_ZERO, 1'b1, 15, 15, "halted_sat");

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        if (!done) begin
            $display("FAIL watchdog: got timeout want completion");
            $fatal(1, "timeout");
        end
    end

endmodule
